matmul_sequencer: RTL
=====================

// Module: matmul_sequencer
// PURPOSE
//  Host-facing controller for one systolic_array instance (N_SIZE x N_SIZE, 16-bit operands, 32-bit results).
//  Buffers operand matrices A and B written element by element by the host.
//  On start, streams A column-wise and B row-wise into the array, then captures the N result rows of C into a readable buffer.
//  Sits between the host register interface and the array; owns the array's valid_in and observes its valid_out.
// PARAMETERS
//  N_SIZE   3          matrix dimension; must match the attached systolic_array
//  TIMEOUT  4*N_SIZE+8 cycles allowed from the last feed beat until the last C row is captured
// PORTS
//  clk          in   1        single clock, rising edge
//  rst_n        in   1        asynchronous active-low reset
//  wr_en        in   1        host operand write strobe
//  wr_sel       in   1        0 = matrix A, 1 = matrix B
//  wr_row       in   clog2(N) element row index
//  wr_col       in   clog2(N) element column index
//  wr_data      in   16       element value
//  start        in   1        one-cycle request to run a multiply
//  busy         out  1        high from start acceptance until done
//  done         out  1        one-cycle pulse when a run ends, normally or on timeout
//  err          out  1        sticky timeout flag; cleared on next accepted start
//  rd_row       in   clog2(N) C read row index
//  rd_col       in   clog2(N) C read column index
//  rd_data      out  32       C[rd_row][rd_col], combinational read
//  arr_valid_in out  1        to systolic_array valid_in
//  arr_a_out    out  16 x N   to matrix_a_in; beat k carries column k of A: arr_a_out[i] = A[i][k]
//  arr_b_out    out  16 x N   to matrix_b_in; beat k carries row k of B: arr_b_out[j] = B[k][j]
//  arr_valid_out in  1        from systolic_array valid_out
//  arr_c_in     in   32 x N   from matrix_c_out; one row of C per valid beat
// BEHAVIOUR
//  Reset: state IDLE; busy, done, err and arr_valid_in are 0; arr_a_out and arr_b_out are 0.
//   A, B and C buffers are all zeroed; all counters are 0.
//  FSM: IDLE -> FEED -> COLLECT -> FIN -> IDLE.
//   IDLE: start=1 is accepted; busy=1 and err=0 from the next cycle.
//   FEED: exactly N consecutive cycles with arr_valid_in=1, beat k=0..N-1.
//    First beat is registered, one cycle after start is sampled. Then -> COLLECT; arr_valid_in=0, operand outputs held.
//   COLLECT: each cycle with arr_valid_out=1 writes arr_c_in into C row r, then r++.
//    Gaps in valid_out are tolerated. After row N-1 is written -> FIN.
//    If the timeout counter reaches TIMEOUT first -> FIN with err=1; unfilled rows keep their old contents.
//   FIN: done=1 for one cycle; busy=0 on the following cycle -> IDLE.
//  Timeout counter: resets on entry to COLLECT and saturates at TIMEOUT.
//  start while busy (FEED, COLLECT, FIN) is ignored and not queued.
//  wr_en while busy is ignored, so operand buffers are stable during a run. Writes in IDLE take effect next cycle.
//  wr_en and start in the same IDLE cycle: the write lands and the run uses the new value (write has priority).
//  arr_valid_out=1 in IDLE or FEED is ignored; C is not modified.
//  rd_data is readable at any time; during a run it returns partial or previous results. C is not cleared at start.
//  Async reset mid-run: returns to IDLE immediately, all buffers zeroed, no done pulse.
//  Arithmetic: no computation in this block; widths are pass-through, 16-bit in and 32-bit captured.
// STRUCTURE
//  Package mm_pkg holds:
//   DATA_W = 16 and ACC_W = 32;
//   typedef seq_state_t, an enum {IDLE, FEED, COLLECT, FIN};
//   typedef operand_t = logic [DATA_W-1:0] and result_t = logic [ACC_W-1:0].
//  One sub-module, mm_operand_bank (N x N x DATA_W register file):
//   host write port;
//   column-slice read port for A and row-slice read port for B.
//   Instantiated twice, once for A and once for B.
//  The FSM, feed/row counters, timeout counter and C buffer stay in matmul_sequencer.
// TESTING (bench drives the real systolic_array #(3) plus a stub array for fault cases)
//  1. Write A={{1,2,3},{4,5,6},{7,8,9}} and B=diag(1,2,3), then start.
//     -> beat 0 arr_a_out={1,4,7}, arr_b_out={1,0,0}; exactly 3 arr_valid_in cycles.
//     -> done pulse; C={{1,4,9},{4,10,18},{7,16,27}}; err=0.
//  2. Start pulsed again during FEED and during COLLECT.
//     -> ignored; single done pulse; C unchanged from scenario 1.
//  3. wr_en to A[0][0]=99 while busy, then read back after done.
//     -> next run still uses A[0][0]=1; a write in IDLE then sets it to 99 and C row 0 becomes {99,4,9}.
//  4. Stub array never asserts valid_out.
//     -> done exactly TIMEOUT+1 cycles after COLLECT entry; err=1; C unchanged; next start clears err.
//  5. Stub array drives valid_out rows with 1-cycle gaps.
//     -> all 3 rows captured in order; no timeout.
//  6. Assert rst_n low in the second FEED beat.
//     -> busy=0, arr_valid_in=0, rd_data=0 for every index; no done pulse; a fresh run then passes scenario 1.

Source files
------------

// File: rtl/mm_pkg.sv
`default_nettype none
// ------------------------------------------------------------------
// mm_pkg - shared widths, state encoding and helpers. Rev 1.0
// ------------------------------------------------------------------
package mm_pkg;

  localparam int DATA_W = 16;
  localparam int ACC_W  = 32;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FEED    = 2'd1,
    COLLECT = 2'd2,
    FIN     = 2'd3
  } seq_state_t;

  typedef logic [DATA_W-1:0] operand_t;
  typedef logic [ACC_W-1:0]  result_t;

  // Index width for an N-entry dimension; never below one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage : mm_pkg
`default_nettype wire

// File: rtl/mm_operand_bank.sv
`default_nettype none
// ------------------------------------------------------------------
// mm_operand_bank - N x N operand register file, host write, one slice read. Rev 1.0
// ------------------------------------------------------------------
module mm_operand_bank
  import mm_pkg::*;
#(
  parameter int N_SIZE    = 3,
  parameter bit COL_SLICE = 1'b1,
  localparam int IDX_W    = idx_w(N_SIZE)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en_i,
  input  logic [IDX_W-1:0]         wr_row_i,
  input  logic [IDX_W-1:0]         wr_col_i,
  input  logic [DATA_W-1:0]        wr_data_i,
  input  logic [IDX_W-1:0]         slice_idx_i,
  output logic [N_SIZE*DATA_W-1:0] slice_o
);

  operand_t mem_q [N_SIZE][N_SIZE];
  operand_t mem_d [N_SIZE][N_SIZE];
  logic     wr_hit;
  logic     idx_ok;

  assign wr_hit = wr_en_i && (int'(wr_row_i) < N_SIZE) && (int'(wr_col_i) < N_SIZE);
  assign idx_ok = (int'(slice_idx_i) < N_SIZE);

  always_comb begin
    mem_d = mem_q;
    if (wr_hit) begin
      mem_d[wr_row_i][wr_col_i] = wr_data_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < N_SIZE; r++) begin
        for (int c = 0; c < N_SIZE; c++) begin
          mem_q[r][c] <= '0;
        end
      end
    end else begin
      mem_q <= mem_d;
    end
  end

  // Slices read the post-write image so a write and a start in the same
  // cycle hand the new element to the first registered beat.
  generate
    if (COL_SLICE) begin : g_col
      for (genvar i = 0; i < N_SIZE; i++) begin : g_elem
        assign slice_o[i*DATA_W +: DATA_W] = idx_ok ? mem_d[i][slice_idx_i] : '0;
      end
    end else begin : g_row
      for (genvar j = 0; j < N_SIZE; j++) begin : g_elem
        assign slice_o[j*DATA_W +: DATA_W] = idx_ok ? mem_d[slice_idx_i][j] : '0;
      end
    end
  endgenerate

endmodule : mm_operand_bank
`default_nettype wire

// File: rtl/matmul_sequencer.sv
`default_nettype none
// ------------------------------------------------------------------
// matmul_sequencer - operand buffers, feed/collect FSM and C buffer for a systolic array. Rev 1.0
// ------------------------------------------------------------------
module matmul_sequencer
  import mm_pkg::*;
#(
  parameter int N_SIZE  = 3,
  parameter int TIMEOUT = 4 * N_SIZE + 8,
  localparam int IDX_W  = idx_w(N_SIZE)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en_i,
  input  logic                     wr_sel_i,
  input  logic [IDX_W-1:0]         wr_row_i,
  input  logic [IDX_W-1:0]         wr_col_i,
  input  logic [DATA_W-1:0]        wr_data_i,
  input  logic                     start_i,
  output logic                     busy_o,
  output logic                     done_o,
  output logic                     err_o,
  input  logic [IDX_W-1:0]         rd_row_i,
  input  logic [IDX_W-1:0]         rd_col_i,
  output logic [ACC_W-1:0]         rd_data_o,
  output logic                     arr_valid_in_o,
  output logic [N_SIZE*DATA_W-1:0] arr_a_out_o,
  output logic [N_SIZE*DATA_W-1:0] arr_b_out_o,
  input  logic                     arr_valid_out_i,
  input  logic [N_SIZE*ACC_W-1:0]  arr_c_in_i
);

  localparam int               CNT_W     = $clog2(N_SIZE + 1);
  localparam int               TMO_W     = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] FEED_LAST = CNT_W'(N_SIZE);
  localparam logic [TMO_W-1:0] TMO_MAX   = TMO_W'(TIMEOUT);
  localparam logic [IDX_W-1:0] ROW_LAST  = IDX_W'(N_SIZE - 1);

  seq_state_t               state_q;
  logic                     busy_q;
  logic                     done_q;
  logic                     err_q;
  logic                     valid_q;
  logic [N_SIZE*DATA_W-1:0] a_q;
  logic [N_SIZE*DATA_W-1:0] b_q;
  logic [CNT_W-1:0]         feed_cnt_q;
  logic [IDX_W-1:0]         row_q;
  logic [TMO_W-1:0]         tmo_q;
  logic [TMO_W-1:0]         tmo_d;
  logic [N_SIZE*ACC_W-1:0]  c_q [N_SIZE];

  logic                     host_wr;
  logic                     feed_more;
  logic [IDX_W-1:0]         feed_idx;
  logic [N_SIZE*DATA_W-1:0] a_slice;
  logic [N_SIZE*DATA_W-1:0] b_slice;
  logic                     row_done;
  logic                     tmo_hit;

  // Operand buffers are frozen for the whole run.
  assign host_wr   = wr_en_i && (state_q == IDLE);
  assign feed_more = (feed_cnt_q < FEED_LAST);
  assign feed_idx  = ((state_q == FEED) && feed_more) ? feed_cnt_q[IDX_W-1:0] : '0;
  assign tmo_d     = tmo_hit ? tmo_q : tmo_q + 1'b1;
  assign tmo_hit   = (tmo_q == TMO_MAX);
  assign row_done  = arr_valid_out_i && (row_q == ROW_LAST);

  mm_operand_bank #(
    .N_SIZE    (N_SIZE),
    .COL_SLICE (1'b1)
  ) u_bank_a (
    .clk         (clk),
    .rst_n       (rst_n),
    .wr_en_i     (host_wr && !wr_sel_i),
    .wr_row_i    (wr_row_i),
    .wr_col_i    (wr_col_i),
    .wr_data_i   (wr_data_i),
    .slice_idx_i (feed_idx),
    .slice_o     (a_slice)
  );

  mm_operand_bank #(
    .N_SIZE    (N_SIZE),
    .COL_SLICE (1'b0)
  ) u_bank_b (
    .clk         (clk),
    .rst_n       (rst_n),
    .wr_en_i     (host_wr && wr_sel_i),
    .wr_row_i    (wr_row_i),
    .wr_col_i    (wr_col_i),
    .wr_data_i   (wr_data_i),
    .slice_idx_i (feed_idx),
    .slice_o     (b_slice)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      valid_q    <= 1'b0;
      a_q        <= '0;
      b_q        <= '0;
      feed_cnt_q <= '0;
      row_q      <= '0;
      tmo_q      <= '0;
      for (int r = 0; r < N_SIZE; r++) begin
        c_q[r] <= '0;
      end
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start_i) begin
            state_q    <= FEED;
            busy_q     <= 1'b1;
            err_q      <= 1'b0;
            valid_q    <= 1'b1;
            a_q        <= a_slice;
            b_q        <= b_slice;
            feed_cnt_q <= CNT_W'(1);
          end
        end
        FEED: begin
          if (feed_more) begin
            valid_q    <= 1'b1;
            a_q        <= a_slice;
            b_q        <= b_slice;
            feed_cnt_q <= feed_cnt_q + 1'b1;
          end else begin
            // Operand outputs stay on the last beat until the next run.
            valid_q <= 1'b0;
            state_q <= COLLECT;
            row_q   <= '0;
            tmo_q   <= '0;
          end
        end
        COLLECT: begin
          tmo_q <= tmo_d;
          if (arr_valid_out_i) begin
            c_q[row_q] <= arr_c_in_i;
            if (!row_done) begin
              row_q <= row_q + 1'b1;
            end
          end
          if (row_done) begin
            state_q <= FIN;
            done_q  <= 1'b1;
          end else if (tmo_hit) begin
            state_q <= FIN;
            done_q  <= 1'b1;
            err_q   <= 1'b1;
          end
        end
        FIN: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  always_comb begin
    rd_data_o = '0;
    if ((int'(rd_row_i) < N_SIZE) && (int'(rd_col_i) < N_SIZE)) begin
      rd_data_o = c_q[rd_row_i][rd_col_i*ACC_W +: ACC_W];
    end
  end

  assign busy_o         = busy_q;
  assign done_o         = done_q;
  assign err_o          = err_q;
  assign arr_valid_in_o = valid_q;
  assign arr_a_out_o    = a_q;
  assign arr_b_out_o    = b_q;

endmodule : matmul_sequencer
`default_nettype wire
